// File: rtl/ysyx_22040895_dmem_resp_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_22040895_dmem_resp_pkg
//   Shared definitions for the data-memory responder and its lane helper.
//   Holds the access-size encodings, the responder state encodings, the data
//   bus width (the same width the core uses for RegBus / InstAddrBus), and a
//   few helpers that turn an access size into byte and bit masks.
//   This package has no ports.
// -----------------------------------------------------------------------------
package ysyx_22040895_dmem_resp_pkg;

  localparam int BUS_W = 64;

  typedef enum logic [1:0] {
    UNIT_B = 2'b00,
    UNIT_H = 2'b01,
    UNIT_W = 2'b10,
    UNIT_D = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte-enable pattern of an access, before it is shifted into its lane.
  function automatic logic [7:0] unit_strb(input logic [1:0] size);
    logic [7:0] m;
    case (unit_e'(size))
      UNIT_B:  m = 8'h01;
      UNIT_H:  m = 8'h03;
      UNIT_W:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Address bits that must be zero for an access of this size to be aligned.
  function automatic logic [2:0] unit_low_mask(input logic [1:0] size);
    logic [2:0] m;
    case (unit_e'(size))
      UNIT_B:  m = 3'b000;
      UNIT_H:  m = 3'b001;
      UNIT_W:  m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // Right-aligned bit mask covering the bytes of an access of this size.
  function automatic logic [BUS_W-1:0] unit_data_mask(input logic [1:0] size);
    logic [BUS_W-1:0] m;
    case (unit_e'(size))
      UNIT_B:  m = 64'h0000_0000_0000_00FF;
      UNIT_H:  m = 64'h0000_0000_0000_FFFF;
      UNIT_W:  m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22040895_dmem_lane.sv
// -----------------------------------------------------------------------------
// ysyx_22040895_dmem_lane
//   Purely combinational byte-lane steering for a 64-bit memory word.
//   Given an access size and the byte offset inside the word it produces the
//   store byte strobes, the store data moved into its lane, and the load data
//   pulled out of a raw word, right-aligned and zero-extended. Bytes that
//   would fall beyond lane 7 are simply shifted out and lost. Intended to be
//   shared with the instruction-memory responder for fetch alignment.
//
// Ports
//   size      in   2   access size (UNIT_B/H/W/D)
//   offset    in   3   byte offset inside the 64-bit word
//   wdata     in   64  store data, right-aligned
//   rword     in   64  raw memory word
//   strb      out  8   byte write strobes, already shifted into place
//   wdata_sh  out  64  store data shifted into its lane
//   rdata     out  64  load data, right-aligned and zero-extended
// -----------------------------------------------------------------------------
module ysyx_22040895_dmem_lane
  import ysyx_22040895_dmem_resp_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [2:0]       offset,
  input  logic [BUS_W-1:0] wdata,
  input  logic [BUS_W-1:0] rword,
  output logic [7:0]       strb,
  output logic [BUS_W-1:0] wdata_sh,
  output logic [BUS_W-1:0] rdata
);

  logic [5:0] bit_off;

  assign bit_off  = {offset, 3'b000};
  assign strb     = unit_strb(size) << offset;
  assign wdata_sh = wdata << bit_off;
  assign rdata    = (rword >> bit_off) & unit_data_mask(size);

endmodule

// File: rtl/ysyx_22040895_dmem_resp.sv
// -----------------------------------------------------------------------------
// ysyx_22040895_dmem_resp
//   Data-memory responder: slave end of the mmu load/store interface. It takes
//   one request at a time, waits a fixed latency, then performs the access on
//   an internal array of DEPTH 64-bit words and holds the response until the
//   mmu takes it. Stores merge only the strobed bytes; loads return the
//   addressed bytes right-aligned and zero-extended. Out-of-range accesses
//   return an error with zero data and never write.
//
// Configuration macro
//   YSYX_22040895_DMEM_ALIGN_CHK_EN
//     defined   : a misaligned access completes with rsp_err_o=1, no write.
//     undefined : the low address bits below the access size are cleared,
//                 so misalignment is silently rounded down.
//
// Parameters
//   DEPTH  number of 64-bit words
//   BASE   byte address of word 0
//   LAT    cycles from accept to response, 1..15
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous active-high reset
//   req_valid_i  in   1   request present
//   req_ready_o  out  1   responder can accept a request (IDLE only)
//   req_we_i     in   1   1 = store, 0 = load
//   req_unit_i   in   2   access size: 00 byte, 01 half, 10 word, 11 dword
//   req_addr_i   in   64  byte address
//   req_wdata_i  in   64  store data, right-aligned
//   rsp_valid_o  out  1   response present
//   rsp_ready_i  in   1   mmu takes the response
//   rsp_rdata_o  out  64  load data, zero for stores and faults
//   rsp_err_o    out  1   access fault
// -----------------------------------------------------------------------------
module ysyx_22040895_dmem_resp
  import ysyx_22040895_dmem_resp_pkg::*;
#(
  parameter int               DEPTH = 4096,
  parameter logic [BUS_W-1:0] BASE  = 64'h8000_0000,
  parameter int               LAT   = 2
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_unit_i,
  input  logic [BUS_W-1:0] req_addr_i,
  input  logic [BUS_W-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [BUS_W-1:0] rsp_rdata_o,
  output logic             rsp_err_o
);

  localparam int               IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BUS_W-1:0] ADDR_LIMIT = BASE + (BUS_W'(DEPTH) << 3);
  localparam logic [3:0]       CNT_INIT   = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  state_e           state;
  state_e           state_n;
  logic [3:0]       cnt;
  logic [3:0]       cnt_n;
  logic             accept;
  logic             enter_resp;

  logic             lat_we;
  logic [1:0]       lat_unit;
  logic [BUS_W-1:0] lat_addr;
  logic [BUS_W-1:0] lat_wdata;

  logic             acc_we;
  logic [1:0]       acc_unit;
  logic [BUS_W-1:0] acc_addr;
  logic [BUS_W-1:0] acc_wdata;
  logic [2:0]       low_mask;
  logic             range_err;
  logic             acc_err;
  logic [BUS_W-1:0] eff_addr;
  logic [IDX_W-1:0] mem_idx;
`ifdef YSYX_22040895_DMEM_ALIGN_CHK_EN
  logic             misalign;
`endif

  logic [7:0]       lane_strb;
  logic [BUS_W-1:0] lane_wdata;
  logic [BUS_W-1:0] lane_rdata;
  logic [BUS_W-1:0] mem_word;
  logic [BUS_W-1:0] bit_mask;
  logic [BUS_W-1:0] merged;

  logic [BUS_W-1:0] mem [DEPTH];

  assign req_ready_o = (state == IDLE);

  // State and latency counter registers. Reset abandons any transaction in
  // flight and returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic. With LAT==1 the accept edge is also the edge that
  // enters RESP, so the access is performed straight from the live request.
  // Otherwise WAIT counts down from LAT-2 and leaves on the edge where the
  // counter reads zero.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          if (LAT == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Capture the request on the accept edge so the mmu is free to change its
  // outputs while we wait out the latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_unit  <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= req_we_i;
      lat_unit  <= req_unit_i;
      lat_addr  <= req_addr_i;
      lat_wdata <= req_wdata_i;
    end
  end

  // Select the access fields (live request in IDLE, latched copy otherwise),
  // then decide faults and the effective word/lane address. The range check
  // always uses the address exactly as presented.
  always_comb begin
    acc_we    = lat_we;
    acc_unit  = lat_unit;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_we    = req_we_i;
      acc_unit  = req_unit_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
    end
    low_mask  = unit_low_mask(acc_unit);
    range_err = (acc_addr < BASE) || (acc_addr >= ADDR_LIMIT);
`ifdef YSYX_22040895_DMEM_ALIGN_CHK_EN
    misalign  = |(acc_addr[2:0] & low_mask);
    eff_addr  = acc_addr;
    acc_err   = range_err | misalign;
`else
    eff_addr  = {acc_addr[BUS_W-1:3], acc_addr[2:0] & ~low_mask};
    acc_err   = range_err;
`endif
    mem_idx   = IDX_W'((eff_addr - BASE) >> 3);
  end

  assign mem_word = mem[mem_idx];

  ysyx_22040895_dmem_lane u_lane (
    .size     (acc_unit),
    .offset   (eff_addr[2:0]),
    .wdata    (acc_wdata),
    .rword    (mem_word),
    .strb     (lane_strb),
    .wdata_sh (lane_wdata),
    .rdata    (lane_rdata)
  );

  // Widen the byte strobes to a bit mask and merge the new bytes over the
  // current word, so the array sees a single full-word write.
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < 8; b++) begin
      bit_mask[b*8 +: 8] = {8{lane_strb[b]}};
    end
    merged = (mem_word & ~bit_mask) | (lane_wdata & bit_mask);
  end

  // Memory write on the edge entering RESP. The array is never cleared, and
  // a reset landing on that same edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !acc_err) begin
      mem[mem_idx] <= merged;
    end
  end

  // Response registers: loaded on the edge entering RESP and held until the
  // mmu handshakes. Stores and faults report zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (enter_resp) begin
      rsp_valid_o <= 1'b1;
      rsp_err_o   <= acc_err;
      rsp_rdata_o <= (acc_err || acc_we) ? '0 : lane_rdata;
    end else if ((state == RESP) && rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_ysyx_22040895_dmem_resp
//   Self-checking bench for the data-memory responder. Expected load data and
//   fault flags are pushed to a scoreboard queue when each request is driven
//   and popped when its response appears. Honors
//   YSYX_22040895_DMEM_ALIGN_CHK_EN for the misalignment expectations.
// -----------------------------------------------------------------------------
module tb_ysyx_22040895_dmem_resp;
  import ysyx_22040895_dmem_resp_pkg::*;

  localparam int          LAT_T   = 2;
  localparam int          DEPTH_T = 4096;
  localparam logic [63:0] BASE_T  = 64'h8000_0000;
  localparam logic [63:0] LIMIT_T = BASE_T + 64'(DEPTH_T) * 64'd8;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_unit_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;

  typedef struct {
    logic [63:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  unit;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd;
    logic        err;
  } txn_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;

  ysyx_22040895_dmem_resp #(
    .DEPTH (DEPTH_T),
    .BASE  (BASE_T),
    .LAT   (LAT_T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_unit_i  (req_unit_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request, push its expectation, wait (bounded) for accept and
  // response. lat counts negedges after the accept edge until rsp_valid_o is
  // seen high. Unless hold is set, the response is taken immediately.
  task automatic run_txn(input txn_t t, input bit hold, output int lat,
                         output logic [63:0] rd, output logic er, output bit tmo);
    int   w;
    exp_t e;
    @(negedge clk);
    req_we_i    = t.we;
    req_unit_i  = t.unit;
    req_addr_i  = t.addr;
    req_wdata_i = t.wdata;
    req_valid_i = 1'b1;
    e.rd  = t.rd;
    e.err = t.err;
    exp_q.push_back(e);
    tmo = 1'b0;
    w   = 0;
    while (req_ready_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (req_ready_o !== 1'b1) tmo = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid_o === 1'b1) break;
    end
    if (rsp_valid_o !== 1'b1) tmo = 1'b1;
    rd = rsp_rdata_o;
    er = rsp_err_o;
    if (!hold) begin
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1 rsp_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_unit_i  = UNIT_D;
    req_addr_i  = BASE_T;
    req_wdata_i = 64'h0;
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got ready=%b valid=%b rdata=%h err=%b, want ready=1 valid=0 rdata=0 err=0",
               req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
    end
    rst         = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL reset_blocks_req: got ready=%b valid=%b, want ready=1 valid=0",
               req_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_store_load();
    txn_t        tab [10];
    int          lat;
    logic [63:0] rd;
    logic        er;
    bit          tmo;
    exp_t        e;
    tab[0] = '{1'b1, UNIT_D, BASE_T,      64'h1122_3344_5566_7788, 64'h0, 1'b0};
    tab[1] = '{1'b0, UNIT_D, BASE_T,      64'h0, 64'h1122_3344_5566_7788, 1'b0};
    tab[2] = '{1'b1, UNIT_B, BASE_T + 3,  64'hAB, 64'h0, 1'b0};
    tab[3] = '{1'b0, UNIT_D, BASE_T,      64'h0, 64'h1122_3344_AB66_7788, 1'b0};
    tab[4] = '{1'b0, UNIT_B, BASE_T + 3,  64'h0, 64'h0000_0000_0000_00AB, 1'b0};
    tab[5] = '{1'b0, UNIT_H, BASE_T + 2,  64'h0, 64'h0000_0000_0000_AB66, 1'b0};
    tab[6] = '{1'b1, UNIT_H, BASE_T + 6,  64'hFFFF_FFFF_FFFF_BEEF, 64'h0, 1'b0};
    tab[7] = '{1'b0, UNIT_D, BASE_T,      64'h0, 64'hBEEF_3344_AB66_7788, 1'b0};
    tab[8] = '{1'b0, UNIT_W, BASE_T + 4,  64'h0, 64'h0000_0000_BEEF_3344, 1'b0};
    tab[9] = '{1'b1, UNIT_W, BASE_T + 8,  64'hCAFE_F00D_DEAD_BEEF, 64'h0, 1'b0};
    foreach (tab[i]) begin
      run_txn(tab[i], 1'b0, lat, rd, er, tmo);
      e = exp_q.pop_front();
      n_cmp++;
      if ({tmo, lat, rd, er} !== {1'b0, LAT_T, e.rd, e.err}) begin
        n_fail++;
        $display("[TB] FAIL store_load[%0d]: got lat=%0d rdata=%h err=%b tmo=%b, want lat=%0d rdata=%h err=%b",
                 i, lat, rd, er, tmo, LAT_T, e.rd, e.err);
      end
    end
  endtask

  task automatic test_misalign();
    txn_t        tab [4];
    int          lat;
    logic [63:0] rd;
    logic        er;
    bit          tmo;
    exp_t        e;
`ifdef YSYX_22040895_DMEM_ALIGN_CHK_EN
    tab[0] = '{1'b0, UNIT_H, BASE_T + 1, 64'h0, 64'h0, 1'b1};
    tab[1] = '{1'b0, UNIT_W, BASE_T + 6, 64'h0, 64'h0, 1'b1};
    tab[2] = '{1'b0, UNIT_D, BASE_T + 5, 64'h0, 64'h0, 1'b1};
`else
    tab[0] = '{1'b0, UNIT_H, BASE_T + 1, 64'h0, 64'h0000_0000_0000_7788, 1'b0};
    tab[1] = '{1'b0, UNIT_W, BASE_T + 6, 64'h0, 64'h0000_0000_BEEF_3344, 1'b0};
    tab[2] = '{1'b0, UNIT_D, BASE_T + 5, 64'h0, 64'hBEEF_3344_AB66_7788, 1'b0};
`endif
    tab[3] = '{1'b0, UNIT_W, BASE_T + 8, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0};
    foreach (tab[i]) begin
      run_txn(tab[i], 1'b0, lat, rd, er, tmo);
      e = exp_q.pop_front();
      n_cmp++;
      if ({tmo, lat, rd, er} !== {1'b0, LAT_T, e.rd, e.err}) begin
        n_fail++;
        $display("[TB] FAIL misalign[%0d]: got lat=%0d rdata=%h err=%b tmo=%b, want lat=%0d rdata=%h err=%b",
                 i, lat, rd, er, tmo, LAT_T, e.rd, e.err);
      end
    end
  endtask

  task automatic test_range();
    txn_t        tab [7];
    int          lat;
    logic [63:0] rd;
    logic        er;
    bit          tmo;
    exp_t        e;
    tab[0] = '{1'b1, UNIT_D, LIMIT_T - 8,           64'h5555_AAAA_5555_AAAA, 64'h0, 1'b0};
    tab[1] = '{1'b0, UNIT_W, 64'h0000_0000_7FFF_FFF8, 64'h0, 64'h0, 1'b1};
    tab[2] = '{1'b1, UNIT_D, 64'h0000_0000_7FFF_FFF8, 64'h0, 64'h0, 1'b1};
    tab[3] = '{1'b1, UNIT_D, LIMIT_T,               64'h0, 64'h0, 1'b1};
    tab[4] = '{1'b0, UNIT_D, BASE_T,                64'h0, 64'hBEEF_3344_AB66_7788, 1'b0};
    tab[5] = '{1'b0, UNIT_D, LIMIT_T - 8,           64'h0, 64'h5555_AAAA_5555_AAAA, 1'b0};
    tab[6] = '{1'b0, UNIT_B, LIMIT_T - 1,           64'h0, 64'h0000_0000_0000_0055, 1'b0};
    foreach (tab[i]) begin
      run_txn(tab[i], 1'b0, lat, rd, er, tmo);
      e = exp_q.pop_front();
      n_cmp++;
      if ({tmo, lat, rd, er} !== {1'b0, LAT_T, e.rd, e.err}) begin
        n_fail++;
        $display("[TB] FAIL range[%0d]: got lat=%0d rdata=%h err=%b tmo=%b, want lat=%0d rdata=%h err=%b",
                 i, lat, rd, er, tmo, LAT_T, e.rd, e.err);
      end
    end
  endtask

  task automatic test_hold();
    txn_t        t;
    int          lat;
    logic [63:0] rd;
    logic        er;
    bit          tmo;
    exp_t        e;
    t = '{1'b0, UNIT_D, BASE_T, 64'h0, 64'hBEEF_3344_AB66_7788, 1'b0};
    run_txn(t, 1'b1, lat, rd, er, tmo);
    e = exp_q.pop_front();
    n_cmp++;
    if ({tmo, lat, rd, er} !== {1'b0, LAT_T, e.rd, e.err}) begin
      n_fail++;
      $display("[TB] FAIL hold_first: got lat=%0d rdata=%h err=%b tmo=%b, want lat=%0d rdata=%h err=%b",
               lat, rd, er, tmo, LAT_T, e.rd, e.err);
    end
    req_we_i    = 1'b1;
    req_unit_i  = UNIT_D;
    req_addr_i  = BASE_T;
    req_wdata_i = 64'h0;
    req_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o} !== {1'b1, e.rd, 1'b0, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL hold_stable[%0d]: got valid=%b rdata=%h err=%b ready=%b, want valid=1 rdata=%h err=0 ready=0",
                 c, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o, e.rd);
      end
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL hold_release: got ready=%b valid=%b, want ready=1 valid=0",
               req_ready_o, rsp_valid_o);
    end
    run_txn(t, 1'b0, lat, rd, er, tmo);
    e = exp_q.pop_front();
    n_cmp++;
    if ({tmo, lat, rd, er} !== {1'b0, LAT_T, e.rd, e.err}) begin
      n_fail++;
      $display("[TB] FAIL hold_ignored_req: got lat=%0d rdata=%h err=%b tmo=%b, want lat=%0d rdata=%h err=%b",
               lat, rd, er, tmo, LAT_T, e.rd, e.err);
    end
  endtask

  task automatic test_reset_mid();
    txn_t        t;
    int          lat;
    logic [63:0] rd;
    logic        er;
    bit          tmo;
    bit          seen;
    exp_t        e;
    t = '{1'b1, UNIT_D, BASE_T + 16, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
    run_txn(t, 1'b0, lat, rd, er, tmo);
    e = exp_q.pop_front();
    n_cmp++;
    if ({tmo, lat, rd, er} !== {1'b0, LAT_T, e.rd, e.err}) begin
      n_fail++;
      $display("[TB] FAIL mid_prestore: got lat=%0d rdata=%h err=%b tmo=%b, want lat=%0d rdata=%h err=%b",
               lat, rd, er, tmo, LAT_T, e.rd, e.err);
    end
    @(negedge clk);
    req_we_i    = 1'b1;
    req_unit_i  = UNIT_B;
    req_addr_i  = BASE_T + 16;
    req_wdata_i = 64'hFF;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2 * LAT_T + 2; c++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if ({seen, req_ready_o} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_abort: got valid_seen=%b ready=%b, want valid_seen=0 ready=1",
               seen, req_ready_o);
    end
    t = '{1'b0, UNIT_D, BASE_T + 16, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
    run_txn(t, 1'b0, lat, rd, er, tmo);
    e = exp_q.pop_front();
    n_cmp++;
    if ({tmo, lat, rd, er} !== {1'b0, LAT_T, e.rd, e.err}) begin
      n_fail++;
      $display("[TB] FAIL mid_readback: got lat=%0d rdata=%h err=%b tmo=%b, want lat=%0d rdata=%h err=%b",
               lat, rd, er, tmo, LAT_T, e.rd, e.err);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_store_load();
    test_misalign();
    test_range();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
